// File: rtl/servo_ramp_seq.sv
// rtl/servo_ramp_seq.sv - servo position ramp sequencer driving 8 PWM duty registers over a bus-master port.
// Optional completion interrupt pulse enabled by defining SERVO_RAMP_IRQ_EN.
module servo_ramp_seq #(
   parameter int          NCH      = 8,
   parameter logic [31:0] STEP_DIV = 32'd50000,
   parameter logic [15:0] PWM_BASE = 16'h0004
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] datain,
   output logic [31:0] dataout,
   input  logic [15:0] addr,
   input  logic        r,
   input  logic        w,
   output logic [15:0] m_addr,
   output logic [31:0] m_dataout,
   output logic        m_w,
   output logic        busy,
   output logic        done_irq
);

   typedef enum logic [1:0] {IDLE, WAIT_TICK, UPDATE, CHECK} state_t;

   state_t      state;
   logic [7:0]  target  [NCH];
   logic [7:0]  current [NCH];
   logic [7:0]  step;
   logic [31:0] prescale;
   logic [31:0] cnt;
   logic [2:0]  k;
   logic        done;

   logic        ctrl_wr, abort_req, start_req;
   logic        is_tgt, is_cur;
   logic [2:0]  ridx;
   logic [31:0] rdata;
   logic [31:0] ps_last;
   logic [7:0]  step_eff, cur_k, tgt_k, diff, next_cur;
   logic        all_eq;

   assign ctrl_wr   = w && (addr == 16'h0000);
   assign abort_req = ctrl_wr && datain[1];
   assign start_req = ctrl_wr && datain[0] && !datain[1];
   assign is_tgt    = (addr >= 16'h0010) && (addr <= 16'h002C) && (addr[1:0] == 2'b00);
   assign is_cur    = (addr >= 16'h0030) && (addr <= 16'h004C) && (addr[1:0] == 2'b00);
   // Both arrays start at an address whose bits [4:2] are 3'b100.
   assign ridx      = addr[4:2] + 3'd4;
   assign ps_last   = (prescale == 32'd0) ? 32'd0 : prescale - 32'd1;

   // Next position for channel k: move toward target by at most STEP, never past it.
   always_comb begin
      step_eff = (step == 8'd0) ? 8'd1 : step;
      cur_k    = current[k];
      tgt_k    = target[k];
      diff     = 8'd0;
      next_cur = cur_k;
      if (cur_k < tgt_k) begin
         diff     = tgt_k - cur_k;
         next_cur = (diff <= step_eff) ? tgt_k : cur_k + step_eff;
      end else if (cur_k > tgt_k) begin
         diff     = cur_k - tgt_k;
         next_cur = (diff <= step_eff) ? tgt_k : cur_k - step_eff;
      end
      all_eq = 1'b1;
      for (int i = 0; i < NCH; i++)
         if (current[i] != target[i]) all_eq = 1'b0;
   end

   always_comb begin
      rdata = 32'd0;
      if (addr == 16'h0004)      rdata = {30'd0, done, busy};
      else if (addr == 16'h0008) rdata = {24'd0, step};
      else if (addr == 16'h000C) rdata = prescale;
      else if (is_tgt)           rdata = {24'd0, target[ridx]};
      else if (is_cur)           rdata = {24'd0, current[ridx]};
   end

`ifndef SERVO_RAMP_IRQ_EN
   assign done_irq = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         dataout   <= 32'd0;
         m_addr    <= 16'd0;
         m_dataout <= 32'd0;
         m_w       <= 1'b0;
         busy      <= 1'b0;
         step      <= 8'd1;
         prescale  <= STEP_DIV;
         cnt       <= 32'd0;
         k         <= 3'd0;
         done      <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            target[i]  <= 8'd0;
            current[i] <= 8'd0;
         end
`ifdef SERVO_RAMP_IRQ_EN
         done_irq  <= 1'b0;
`endif
      end else begin
         m_w <= 1'b0;
`ifdef SERVO_RAMP_IRQ_EN
         done_irq <= 1'b0;
`endif
         if (r) dataout <= rdata;

         // Abort skips the FSM entirely so the in-flight channel update is dropped.
         if (abort_req) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start_req) begin
                     state <= WAIT_TICK;
                     cnt   <= 32'd0;
                     busy  <= 1'b1;
                  end
               end
               WAIT_TICK: begin
                  if (cnt >= ps_last) begin
                     state <= UPDATE;
                     k     <= 3'd0;
                  end else begin
                     cnt <= cnt + 32'd1;
                  end
               end
               UPDATE: begin
                  current[k] <= next_cur;
                  m_w        <= 1'b1;
                  m_addr     <= PWM_BASE + {11'd0, k, 2'b00};
                  m_dataout  <= {24'd0, next_cur};
                  if (k == 3'(NCH - 1)) state <= CHECK;
                  else                  k     <= k + 3'd1;
               end
               CHECK: begin
                  if (all_eq) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
`ifdef SERVO_RAMP_IRQ_EN
                     done_irq <= 1'b1;
`endif
                  end else begin
                     state <= WAIT_TICK;
                     cnt   <= 32'd0;
                  end
               end
               default: state <= IDLE;
            endcase
         end

         // Placed after the FSM so a CTRL write beats a same-cycle completion.
         if (w) begin
            if (ctrl_wr)                done           <= 1'b0;
            else if (addr == 16'h0008)  step           <= datain[7:0];
            else if (addr == 16'h000C)  prescale       <= datain;
            else if (is_tgt)            target[ridx]   <= datain[7:0];
         end
      end
   end

endmodule

// File: tb/tb_servo_ramp_seq.sv
// tb/tb_servo_ramp_seq.sv - scoreboard bench for servo_ramp_seq.
module tb_servo_ramp_seq;

   localparam logic [15:0] A_CTRL = 16'h0000;
   localparam logic [15:0] A_STAT = 16'h0004;
   localparam logic [15:0] A_STEP = 16'h0008;
   localparam logic [15:0] A_PRE  = 16'h000C;
`ifdef SERVO_RAMP_IRQ_EN
   localparam int EXP_IRQ = 1;
`else
   localparam int EXP_IRQ = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] datain = 32'd0;
   logic [31:0] dataout;
   logic [15:0] addr = 16'd0;
   logic        r = 1'b0;
   logic        w = 1'b0;
   logic [15:0] m_addr;
   logic [31:0] m_dataout;
   logic        m_w;
   logic        busy;
   logic        done_irq;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int wr_cyc = 0;
   int irq_cnt = 0;
   int burst_cyc[$];
   logic [47:0] sb[$];
   logic        mw_prev = 1'b0;

   logic [7:0] mtgt [8];
   logic [7:0] mcur [8];
   logic [7:0] mstep;

   servo_ramp_seq dut (
      .clk(clk), .reset(reset), .datain(datain), .dataout(dataout),
      .addr(addr), .r(r), .w(w), .m_addr(m_addr), .m_dataout(m_dataout),
      .m_w(m_w), .busy(busy), .done_irq(done_irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      logic [47:0] exp_w;
      if (reset) begin
         mw_prev = 1'b0;
      end else begin
         if (done_irq) irq_cnt++;
         if (m_w) begin
            if (!mw_prev) burst_cyc.push_back(cyc);
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL pwm_write unexpected addr=%h data=%h", m_addr, m_dataout);
            end else begin
               exp_w = sb.pop_front();
               if ({m_addr, m_dataout} !== exp_w) begin
                  bad++;
                  $display("FAIL pwm_write got addr=%h data=%h expected addr=%h data=%h",
                           m_addr, m_dataout, exp_w[47:32], exp_w[31:0]);
               end
            end
         end
         mw_prev = m_w;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] step_one(input logic [7:0] c, input logic [7:0] t, input logic [7:0] s);
      logic [7:0] se;
      se = (s == 8'd0) ? 8'd1 : s;
      if (c < t) return ((t - c) <= se) ? t : c + se;
      if (c > t) return ((c - t) <= se) ? t : c - se;
      return c;
   endfunction

   function automatic bit model_eq();
      for (int i = 0; i < 8; i++) if (mcur[i] != mtgt[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         mtgt[i] = 8'd0;
         mcur[i] = 8'd0;
      end
      mstep = 8'd1;
   endtask

   task automatic push_burst(input int n);
      for (int kk = 0; kk < n; kk++) begin
         mcur[kk] = step_one(mcur[kk], mtgt[kk], mstep);
         sb.push_back({16'h0004 + 16'(4 * kk), 24'h0, mcur[kk]});
      end
   endtask

   task automatic push_ramp(output int nb);
      nb = 0;
      do begin
         push_burst(8);
         nb++;
      end while (!model_eq() && nb < 300);
   endtask

   task automatic wr(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      addr = a; datain = d; w = 1'b1;
      @(negedge clk);
      w = 1'b0;
      wr_cyc = cyc;
   endtask

   task automatic rd(input logic [15:0] a, output logic [31:0] d);
      @(negedge clk);
      addr = a; r = 1'b1;
      @(negedge clk);
      r = 1'b0;
      d = dataout;
   endtask

   task automatic wait_idle(input int bound);
      bit seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(negedge clk);
         if (!busy) seen = 1'b1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL wait_idle busy=%b required=0 after %0d cycles", busy, bound);
      end
   endtask

   task automatic check_run(input string name, input int b0, input int nb, input int lat_exp, input int per_exp, input int s);
      int lat, per;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL %s_missing_writes left=%0d required=0", name, sb.size());
      end
      total++;
      if (burst_cyc.size() - b0 != nb) begin
         bad++;
         $display("FAIL %s_bursts got=%0d required=%0d", name, burst_cyc.size() - b0, nb);
      end
      lat = (burst_cyc.size() > b0) ? burst_cyc[b0] - s : -1;
      total++;
      if (lat != lat_exp) begin
         bad++;
         $display("FAIL %s_latency got=%0d required=%0d", name, lat, lat_exp);
      end
      if (per_exp > 0) begin
         per = (burst_cyc.size() > b0 + 1) ? burst_cyc[b0 + 1] - burst_cyc[b0] : -1;
         total++;
         if (per != per_exp) begin
            bad++;
            $display("FAIL %s_period got=%0d required=%0d", name, per, per_exp);
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      repeat (3) @(negedge clk);
      total++;
      if ({dataout, m_addr, m_dataout, m_w, busy, done_irq} !== 84'd0) begin
         bad++;
         $display("FAIL reset_outputs got=%h required=0", {dataout, m_addr, m_dataout, m_w, busy, done_irq});
      end
      reset = 1'b0;
      rd(A_STAT, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_status got=%h required=0", d); end
      rd(A_PRE, d);
      total++; if (d !== 32'd50000) begin bad++; $display("FAIL reset_prescale got=%0d required=50000", d); end
      rd(A_STEP, d);
      total++; if (d !== 32'd1) begin bad++; $display("FAIL reset_step got=%0d required=1", d); end
      rd(16'h0080, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL unmapped_read got=%h required=0", d); end
   endtask

   task automatic test_single_ramp();
      int nb, b0, i0, s;
      logic [31:0] d;
      wr(A_PRE, 4); wr(A_STEP, 10); wr(16'h0010, 25);
      mstep = 8'd10; mtgt[0] = 8'd25;
      push_ramp(nb);
      b0 = burst_cyc.size(); i0 = irq_cnt;
      wr(A_CTRL, 1); s = wr_cyc;
      wait_idle(300);
      check_run("single", b0, 3, 5, 13, s);
      total++; if (nb != 3) begin bad++; $display("FAIL single_model_bursts got=%0d required=3", nb); end
      rd(A_STAT, d);
      total++; if (d !== 32'd2) begin bad++; $display("FAIL single_status got=%h required=2", d); end
      total++;
      if (irq_cnt - i0 != EXP_IRQ) begin
         bad++;
         $display("FAIL single_irq got=%0d required=%0d", irq_cnt - i0, EXP_IRQ);
      end
   endtask

   task automatic test_clamp();
      int nb, b0, s;
      logic [31:0] d;
      wr(A_STEP, 200); wr(16'h001C, 200); wr(16'h0014, 250);
      mstep = 8'd200; mtgt[3] = 8'd200; mtgt[1] = 8'd250;
      push_ramp(nb);
      b0 = burst_cyc.size();
      wr(A_CTRL, 1); s = wr_cyc;
      wait_idle(300);
      check_run("clamp_pre", b0, 2, 5, 13, s);
      wr(A_STEP, 10); wr(16'h001C, 195); wr(16'h0014, 255);
      mstep = 8'd10; mtgt[3] = 8'd195; mtgt[1] = 8'd255;
      push_ramp(nb);
      b0 = burst_cyc.size();
      wr(A_CTRL, 1); s = wr_cyc;
      wait_idle(300);
      check_run("clamp", b0, 1, 5, 0, s);
      rd(16'h003C, d);
      total++; if (d !== 32'd195) begin bad++; $display("FAIL clamp_down_current got=%0d required=195", d); end
      rd(16'h0034, d);
      total++; if (d !== 32'd255) begin bad++; $display("FAIL clamp_up_current got=%0d required=255", d); end
   endtask

   task automatic test_step_zero();
      int nb, b0, s;
      logic [31:0] d;
      wr(A_STEP, 0); wr(A_PRE, 0); wr(16'h002C, 3);
      mstep = 8'd0; mtgt[7] = 8'd3;
      push_ramp(nb);
      b0 = burst_cyc.size();
      wr(A_CTRL, 1); s = wr_cyc;
      wait_idle(300);
      check_run("step_zero", b0, 3, 2, 10, s);
      rd(16'h004C, d);
      total++; if (d !== 32'd3) begin bad++; $display("FAIL step_zero_current got=%0d required=3", d); end
   endtask

   task automatic test_abort();
      int rises, i0;
      logic pm;
      logic [31:0] d;
      wr(A_PRE, 4); wr(A_STEP, 1); wr(16'h0018, 100);
      mstep = 8'd1; mtgt[2] = 8'd100;
      push_burst(8);
      push_burst(1);
      i0 = irq_cnt;
      wr(A_CTRL, 1);
      rises = 0; pm = 1'b0;
      for (int i = 0; i < 200 && rises < 2; i++) begin
         @(negedge clk);
         if (m_w && !pm) rises++;
         pm = m_w;
      end
      total++;
      if (rises < 2) begin
         bad++;
         $display("FAIL abort_second_burst seen=%0d required=2", rises);
      end
      addr = A_CTRL; datain = 32'd2; w = 1'b1;
      @(negedge clk);
      w = 1'b0;
      total++;
      if ({m_w, busy} !== 2'b00) begin
         bad++;
         $display("FAIL abort_stop m_w=%b busy=%b required=0,0", m_w, busy);
      end
      repeat (20) @(negedge clk);
      total++; if (sb.size() != 0) begin bad++; $display("FAIL abort_writes left=%0d required=0", sb.size()); end
      rd(A_STAT, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL abort_status got=%h required=0", d); end
      rd(16'h0038, d);
      total++; if (d !== 32'd1) begin bad++; $display("FAIL abort_current got=%0d required=1", d); end
      total++; if (irq_cnt != i0) begin bad++; $display("FAIL abort_irq got=%0d required=0", irq_cnt - i0); end
   endtask

   task automatic test_retarget();
      int nb, b0, s;
      logic [31:0] d;
      wr(16'h0018, 1); wr(A_STEP, 35); wr(16'h0010, 60); wr(A_PRE, 4);
      mtgt[2] = 8'd1; mstep = 8'd35; mtgt[0] = 8'd60;
      push_ramp(nb);
      b0 = burst_cyc.size();
      wr(A_CTRL, 1); s = wr_cyc;
      wait_idle(300);
      check_run("retarget_pre", b0, 1, 5, 0, s);
      wr(A_PRE, 20); wr(A_STEP, 20); wr(16'h0010, 100);
      mstep = 8'd20;
      b0 = burst_cyc.size();
      wr(A_CTRL, 1); s = wr_cyc;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL retarget_busy got=%b required=1", busy); end
      wr(16'h0010, 50);
      wr(A_CTRL, 1);
      mtgt[0] = 8'd50;
      push_ramp(nb);
      wait_idle(300);
      check_run("retarget", b0, 1, 21, 0, s);
      rd(A_STAT, d);
      total++; if (d !== 32'd2) begin bad++; $display("FAIL retarget_status got=%h required=2", d); end
      rd(16'h0030, d);
      total++; if (d !== 32'd50) begin bad++; $display("FAIL retarget_current got=%0d required=50", d); end
   endtask

   task automatic test_reset_mid_burst();
      bit seen;
      logic [31:0] d;
      wr(A_PRE, 4); wr(A_STEP, 1); wr(16'h0024, 200);
      mstep = 8'd1; mtgt[5] = 8'd200;
      push_burst(8);
      wr(A_CTRL, 1);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (m_w) seen = 1'b1;
      end
      total++; if (!seen) begin bad++; $display("FAIL midreset_burst seen=0 required=1"); end
      #2 reset = 1'b1;
      #1;
      total++;
      if ({m_w, busy, m_addr, m_dataout, done_irq} !== 51'd0) begin
         bad++;
         $display("FAIL midreset_outputs got=%h required=0", {m_w, busy, m_addr, m_dataout, done_irq});
      end
      sb.delete();
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      rd(A_STAT, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL midreset_status got=%h required=0", d); end
      rd(16'h0044, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL midreset_current5 got=%0d required=0", d); end
      rd(16'h0030, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL midreset_current0 got=%0d required=0", d); end
      rd(16'h0010, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL midreset_target0 got=%0d required=0", d); end
      rd(A_PRE, d);
      total++; if (d !== 32'd50000) begin bad++; $display("FAIL midreset_prescale got=%0d required=50000", d); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_ramp();
      test_clamp();
      test_step_zero();
      test_abort();
      test_retarget();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
